operand_loader_master: RTL and testbench

OPERAND_LOADER_MASTER -- requirements
Module: operand_loader_master

---
 rtl/operand_loader_master.sv | 107 ++++++++++
 tb/tb_operand_loader_master.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/operand_loader_master.sv
// Operand loader: accepts an (A, B) pair on a valid/ready handshake and writes A to word 0, then B to word 1, over Avalon-MM.
// Optional waitrequest timeout is enabled by defining AVM_TIMEOUT_EN.
module operand_loader_master #(
  parameter int N         = 32,
  parameter int TO_CYCLES = 16
) (
  input  logic         csi_clk,
  input  logic         rsi_srst,
  input  logic         coe_valid,
  output logic         coe_ready,
  input  logic [N-1:0] coe_A,
  input  logic [N-1:0] coe_B,
  output logic         coe_done,
  output logic         coe_err,
  output logic [7:0]   avm_m0_address,
  output logic         avm_m0_write,
  output logic [N-1:0] avm_m0_writedata,
  input  logic         avm_m0_waitrequest
);

  typedef enum logic [1:0] {IDLE, WR_A, WR_B} state_t;

  state_t         state, state_nxt;
  logic [N-1:0]   b_q;
  logic           ready_nxt, write_nxt, done_nxt;
  logic [7:0]     addr_nxt;
  logic [N-1:0]   data_nxt;
  logic           handshake, accept, timeout;

  assign handshake = coe_valid & coe_ready;
  assign accept    = avm_m0_write & ~avm_m0_waitrequest;

`ifdef AVM_TIMEOUT_EN
  localparam int CW = $clog2(TO_CYCLES + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TO_CYCLES - 1);

  logic [CW-1:0] to_cnt;

  // The stall that would bring the count to TO_CYCLES is the one that aborts.
  assign timeout = avm_m0_write & avm_m0_waitrequest & (to_cnt == TO_LAST);

  always_ff @(posedge csi_clk) begin
    if (rsi_srst) begin
      to_cnt  <= '0;
      coe_err <= 1'b0;
    end else begin
      to_cnt <= (avm_m0_write & avm_m0_waitrequest & ~timeout) ? to_cnt + 1'b1 : '0;
      if (timeout) coe_err <= 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
  assign coe_err = 1'b0;
`endif

  // State register plus the registered outputs, which are loaded from their next values.
  always_ff @(posedge csi_clk) begin
    if (rsi_srst) begin
      state            <= IDLE;
      b_q              <= '0;
      coe_ready        <= 1'b0;
      coe_done         <= 1'b0;
      avm_m0_write     <= 1'b0;
      avm_m0_address   <= '0;
      avm_m0_writedata <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state            <= state_nxt;
      coe_ready        <= ready_nxt;
      coe_done         <= done_nxt;
      avm_m0_write     <= write_nxt;
      avm_m0_address   <= addr_nxt;
      avm_m0_writedata <= data_nxt;
      if (handshake) b_q <= coe_B;
    end
  end

  always_comb begin
    // NOTE: default first so no path leaves state_nxt unassigned (no latch).
    state_nxt = state;
    unique case (state)
      IDLE: if (handshake)          state_nxt = WR_A;
      WR_A: if (timeout)            state_nxt = IDLE;
            else if (accept)        state_nxt = WR_B;
      WR_B: if (timeout || accept)  state_nxt = IDLE;
      default:                      state_nxt = IDLE;
    endcase
  end

  // A goes straight into the writedata register at the handshake, so it needs no
  // separate capture register; only B is held for the second write.
  always_comb begin
    write_nxt = (state_nxt != IDLE);
    ready_nxt = (state_nxt == IDLE);
    done_nxt  = (state == WR_B) && accept;
    addr_nxt  = avm_m0_address;
    data_nxt  = avm_m0_writedata;
    if (state == IDLE && handshake) begin
      addr_nxt = 8'd0;
      data_nxt = coe_A;
    end else if (state == WR_A && accept) begin
      addr_nxt = 8'd1;
      data_nxt = b_q;
    end
  end

endmodule

// File: tb/tb_operand_loader_master.sv
// Randomized and directed bench for operand_loader_master against a transaction-queue reference model.
// Define AVM_TIMEOUT_EN to also exercise the waitrequest timeout (TO_CYCLES=4).
module tb_operand_loader_master;

  localparam int N  = 32;
  localparam int TO = 4;

  logic         clk = 1'b0;
  logic         srst;
  logic         valid;
  logic         ready;
  logic [N-1:0] a_in, b_in;
  logic         done, err;
  logic [7:0]   address;
  logic         write;
  logic [N-1:0] writedata;
  logic         waitreq;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  operand_loader_master #(.N(N), .TO_CYCLES(TO)) dut (
    .csi_clk            (clk),
    .rsi_srst           (srst),
    .coe_valid          (valid),
    .coe_ready          (ready),
    .coe_A              (a_in),
    .coe_B              (b_in),
    .coe_done           (done),
    .coe_err            (err),
    .avm_m0_address     (address),
    .avm_m0_write       (write),
    .avm_m0_writedata   (writedata),
    .avm_m0_waitrequest (waitreq)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", tag, $time, act, exp);
    end
  endtask

  // Reference model: pending Avalon writes kept as a queue of (address, data).
  typedef struct packed {
    logic [7:0]   addr;
    logic [N-1:0] data;
  } wr_t;

  typedef struct packed {
    logic         write;
    logic [7:0]   addr;
    logic [N-1:0] data;
    logic         ready;
    logic         done;
    logic         err;
  } exp_t;

  initial begin : model
    exp_t e;
    wr_t  q[$];
    bit   have_exp = 0;
    int   stalls = 0;
    e = '0;
    forever begin
      @(negedge clk);
      if (have_exp) begin
        check("write", 64'(write), 64'(e.write));
        check("address", 64'(address), 64'(e.addr));
        check("writedata", 64'(writedata), 64'(e.data));
        check("ready", 64'(ready), 64'(e.ready));
        check("done", 64'(done), 64'(e.done));
        check("err", 64'(err), 64'(e.err));
      end
      // Predict the outputs after the coming edge from the inputs it will sample.
      if (srst) begin
        e = '0;
        q.delete();
        stalls = 0;
        have_exp = 1;
      end else if (have_exp) begin
        e.done = 1'b0;
        if (e.write) begin
          if (!waitreq) begin
            void'(q.pop_front());
            stalls = 0;
            if (q.size() == 0) begin
              e.write = 1'b0;
              e.ready = 1'b1;
              e.done  = 1'b1;
            end else begin
              e.addr = q[0].addr;
              e.data = q[0].data;
            end
          end else begin
            stalls++;
`ifdef AVM_TIMEOUT_EN
            if (stalls == TO) begin
              e.write = 1'b0;
              e.ready = 1'b1;
              e.err   = 1'b1;
              q.delete();
              stalls = 0;
            end
`endif
          end
        end else if (e.ready && valid) begin
          q.push_back('{addr: 8'd0, data: a_in});
          q.push_back('{addr: 8'd1, data: b_in});
          e.write = 1'b1;
          e.ready = 1'b0;
          e.addr  = 8'd0;
          e.data  = a_in;
        end else begin
          e.ready = 1'b1;
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Offer a pair, hold it until the handshake edge, then withdraw it.
  task automatic send(input logic [N-1:0] a, input logic [N-1:0] b);
    bit got = 0;
    valid = 1'b1;
    a_in  = a;
    b_in  = b;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ready) begin
        got = 1;
        break;
      end
    end
    if (!got) check("handshake_wait", 64'(ready), 64'(1));
    @(posedge clk);
    #1;
    valid = 1'b0;
  endtask

  initial begin
    srst    = 1'b1;
    valid   = 1'b0;
    a_in    = '0;
    b_in    = '0;
    waitreq = 1'b0;
    step(2);
    srst = 1'b0;
    step(3);

    // Single pair, no stalls.
    send(32'h5, 32'h3);
    step(4);

    // Three stalled cycles on the B write.
    send(32'h5, 32'h3);
    step(1);
    waitreq = 1'b1;
    step(3);
    waitreq = 1'b0;
    step(4);

    // Back-to-back pairs; A/B changes while not ready must be ignored.
    valid = 1'b1;
    a_in  = 32'h1;
    b_in  = 32'h2;
    step(1);
    a_in  = 32'h99;
    b_in  = 32'h98;
    step(1);
    a_in  = 32'h3;
    b_in  = 32'h4;
    step(2);
    valid = 1'b0;
    step(4);

    // Reset while the A write is outstanding.
    send(32'h7, 32'h8);
    srst = 1'b1;
    step(1);
    srst = 1'b0;
    step(2);
    send(32'h5, 32'h3);
    step(4);

`ifdef AVM_TIMEOUT_EN
    // Responder never accepts: the A write must time out and err must stick.
    waitreq = 1'b1;
    send(32'h9, 32'ha);
    step(8);
    waitreq = 1'b0;
    step(3);
    srst = 1'b1;
    step(1);
    srst = 1'b0;
    step(2);
`endif

    for (int i = 0; i < 400; i++) begin
      valid   = 1'($urandom % 2);
      a_in    = $urandom;
      b_in    = $urandom;
      waitreq = ($urandom % 4) == 0;
      step(1);
    end
    valid   = 1'b0;
    waitreq = 1'b0;
    step(5);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
